// File: rtl/temp_sense_sequencer.sv
// temp_sense_sequencer: powers the sensor, settles, drops the first sample, averages, raises alarms, watchdogs
module temp_sense_sequencer #(
    parameter int SETTLE_CYCLES  = 64,
    parameter int AVG_LOG2       = 2,
    parameter int PERIOD_CYCLES  = 4096,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int TEMP_W         = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              meas_req,
    output logic              meas_ack,
    input  logic              periodic_en,
    output logic              sensor_en,
    input  logic              sample_valid,
    input  logic [TEMP_W-1:0] sample_temp,
    input  logic [TEMP_W-1:0] hi_thresh,
    input  logic [TEMP_W-1:0] lo_thresh,
    output logic [TEMP_W-1:0] temp_avg,
    output logic              temp_valid,
    output logic              alarm_hi,
    output logic              alarm_lo,
    output logic              busy,
    output logic              timeout_err,
    input  logic              clear_err
);
    localparam int ACC_W   = TEMP_W + AVG_LOG2;
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PER_W   = $clog2(PERIOD_CYCLES);
    localparam int NS_W    = AVG_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, SETTLE, DISCARD, ACCUM} state_t;

    state_t                  state_q, state_d;
    logic [PER_W-1:0]        per_q, per_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum;
    logic [NS_W-1:0]         nsamp_q, nsamp_d;
    logic                    req_pend_q, req_pend_d, tick_pend_q, tick_pend_d;
    logic                    req_owned_q, req_owned_d;
    logic [TEMP_W-1:0]       temp_avg_q, temp_avg_d, avg;
    logic                    temp_valid_q, temp_valid_d, meas_ack_q, meas_ack_d;
    logic                    alarm_hi_q, alarm_hi_d, alarm_lo_q, alarm_lo_d;
    logic                    err_q, err_d;
    logic                    tick;

    // Sum fits in TEMP_W+AVG_LOG2 bits; arithmetic shift floors toward minus infinity
    assign sum = acc_q + ACC_W'($signed(sample_temp));
    assign avg = TEMP_W'(sum >>> AVG_LOG2);

    // Free-running periodic trigger, held at zero while disabled
    always_comb begin
        tick  = periodic_en && (per_q == PER_W'(PERIOD_CYCLES - 1));
        per_d = (!periodic_en || tick) ? '0 : per_q + PER_W'(1);
    end

    // Sequencer: cnt_q is the settle timer in SETTLE and the watchdog in DISCARD/ACCUM
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        acc_d        = acc_q;
        nsamp_d      = nsamp_q;
        req_pend_d   = req_pend_q | meas_req;
        tick_pend_d  = tick_pend_q | tick;
        req_owned_d  = req_owned_q;
        temp_avg_d   = temp_avg_q;
        alarm_hi_d   = alarm_hi_q;
        alarm_lo_d   = alarm_lo_q;
        temp_valid_d = 1'b0;
        meas_ack_d   = 1'b0;
        err_d        = clear_err ? 1'b0 : err_q;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                acc_d   = '0;
                nsamp_d = '0;
                if (req_pend_d || tick_pend_d) begin
                    state_d     = SETTLE;
                    req_owned_d = req_pend_d;
                    req_pend_d  = 1'b0;
                    tick_pend_d = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = DISCARD;
                    cnt_d   = '0;
                end
            end
            DISCARD, ACCUM: begin
                if (sample_valid) begin
                    cnt_d = CNT_W'(1);
                    if (state_q == DISCARD) begin
                        state_d = ACCUM;
                        cnt_d   = '0;
                    end else begin
                        acc_d   = sum;
                        nsamp_d = nsamp_q + NS_W'(1);
                        if (nsamp_q == NS_W'((1 << AVG_LOG2) - 1)) begin
                            state_d      = IDLE;
                            temp_avg_d   = avg;
                            alarm_hi_d   = $signed(avg) >= $signed(hi_thresh);
                            alarm_lo_d   = $signed(avg) <= $signed(lo_thresh);
                            temp_valid_d = 1'b1;
                            meas_ack_d   = req_owned_q;
                        end
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    meas_ack_d = req_owned_q;
                end
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            per_q        <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            nsamp_q      <= '0;
            req_pend_q   <= 1'b0;
            tick_pend_q  <= 1'b0;
            req_owned_q  <= 1'b0;
            temp_avg_q   <= '0;
            temp_valid_q <= 1'b0;
            meas_ack_q   <= 1'b0;
            alarm_hi_q   <= 1'b0;
            alarm_lo_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_q        <= per_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            nsamp_q      <= nsamp_d;
            req_pend_q   <= req_pend_d;
            tick_pend_q  <= tick_pend_d;
            req_owned_q  <= req_owned_d;
            temp_avg_q   <= temp_avg_d;
            temp_valid_q <= temp_valid_d;
            meas_ack_q   <= meas_ack_d;
            alarm_hi_q   <= alarm_hi_d;
            alarm_lo_q   <= alarm_lo_d;
            err_q        <= err_d;
        end
    end

    assign busy        = state_q != IDLE;
    assign sensor_en   = busy;
    assign temp_avg    = temp_avg_q;
    assign temp_valid  = temp_valid_q;
    assign meas_ack    = meas_ack_q;
    assign alarm_hi    = alarm_hi_q;
    assign alarm_lo    = alarm_lo_q;
    assign timeout_err = err_q;
endmodule

// File: tb/tb_temp_sense_sequencer.sv
// tb_temp_sense_sequencer: directed and randomized checks against a timestamp/queue reference model
module tb_temp_sense_sequencer;
    localparam int S = 4, L = 2, P = 50, T = 16, NS = 1 << L;

    logic       clk = 1'b0;
    logic       reset_n, meas_req, periodic_en, sample_valid, clear_err;
    logic [8:0] sample_temp, hi_thresh, lo_thresh, temp_avg;
    logic       meas_ack, sensor_en, temp_valid, alarm_hi, alarm_lo, busy, timeout_err;
    logic       z_req, z_valid;
    logic [8:0] z_temp, z_avg;
    logic       z_ack, z_en, z_tv, z_hi, z_lo, z_busy, z_err;
    int         n_vec = 0, n_err = 0, n;
    bit         quiet = 1'b0;

    // Reference model state: measurements tracked by start/deadline timestamps and a sample queue
    int         cyc = 0, en_run = 0, m_start = 0, m_ref = 0;
    bit         m_busy, m_owned, m_rp, m_tp, m_disc;
    int         q[$];
    logic [8:0] e_avg;
    bit         e_valid, e_ack, e_hi, e_lo, e_err;

    temp_sense_sequencer #(.SETTLE_CYCLES(S), .AVG_LOG2(L), .PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T), .TEMP_W(9)) dut (
        .clk(clk), .reset_n(reset_n), .meas_req(meas_req), .meas_ack(meas_ack), .periodic_en(periodic_en),
        .sensor_en(sensor_en), .sample_valid(sample_valid), .sample_temp(sample_temp), .hi_thresh(hi_thresh),
        .lo_thresh(lo_thresh), .temp_avg(temp_avg), .temp_valid(temp_valid), .alarm_hi(alarm_hi),
        .alarm_lo(alarm_lo), .busy(busy), .timeout_err(timeout_err), .clear_err(clear_err));

    temp_sense_sequencer #(.SETTLE_CYCLES(S), .AVG_LOG2(0), .PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T), .TEMP_W(9)) dut0 (
        .clk(clk), .reset_n(reset_n), .meas_req(z_req), .meas_ack(z_ack), .periodic_en(1'b0),
        .sensor_en(z_en), .sample_valid(z_valid), .sample_temp(z_temp), .hi_thresh(hi_thresh),
        .lo_thresh(lo_thresh), .temp_avg(z_avg), .temp_valid(z_tv), .alarm_hi(z_hi),
        .alarm_lo(z_lo), .busy(z_busy), .timeout_err(z_err), .clear_err(1'b0));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one cycle using the inputs applied during that cycle
    task automatic model_step();
        bit tick;
        int s, a;
        tick = periodic_en && (en_run % P == P - 1);
        e_valid = 0;
        e_ack = 0;
        if (!reset_n) begin
            en_run = 0; m_busy = 0; m_rp = 0; m_tp = 0; m_owned = 0;
            e_avg = '0; e_hi = 0; e_lo = 0; e_err = 0; q.delete();
        end else begin
            en_run = periodic_en ? en_run + 1 : 0;
            if (clear_err) e_err = 0;
            if (!m_busy) begin
                if (m_rp || m_tp || meas_req || tick) begin
                    m_busy = 1; m_owned = m_rp || meas_req; m_rp = 0; m_tp = 0;
                    m_start = cyc + 1; m_ref = cyc + 1 + S; m_disc = 0; q.delete();
                end
            end else begin
                m_rp |= meas_req;
                m_tp |= tick;
                if (cyc >= m_start + S) begin
                    if (sample_valid && !m_disc) begin
                        m_disc = 1;
                        m_ref = cyc + 1;
                    end else if (sample_valid) begin
                        q.push_back(int'($signed(sample_temp)));
                        m_ref = cyc;
                        if (q.size() == NS) begin
                            s = 0;
                            foreach (q[i]) s += q[i];
                            a = s / NS;
                            if (s < 0 && s % NS != 0) a -= 1;
                            e_avg = 9'(a);
                            e_hi = a >= int'($signed(hi_thresh));
                            e_lo = a <= int'($signed(lo_thresh));
                            e_valid = 1; e_ack = m_owned; m_busy = 0;
                        end
                    end else if (cyc == m_ref + T - 1) begin
                        e_err = 1; e_ack = m_owned; m_busy = 0;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("busy", busy, m_busy);
        check("sensor_en", sensor_en, m_busy);
        check("temp_avg", temp_avg, e_avg);
        check("temp_valid", temp_valid, e_valid);
        check("meas_ack", meas_ack, e_ack);
        check("alarm_hi", alarm_hi, e_hi);
        check("alarm_lo", alarm_lo, e_lo);
        check("timeout_err", timeout_err, e_err);
    endtask

    task automatic feed(input logic [8:0] v);
        sample_valid = 1;
        sample_temp = v;
        step();
        sample_valid = 0;
    endtask

    task automatic request();
        meas_req = 1;
        step();
        meas_req = 0;
    endtask

    initial begin
        reset_n = 0; meas_req = 0; periodic_en = 0; sample_valid = 0; clear_err = 0;
        sample_temp = '0; hi_thresh = 9'd100; lo_thresh = 9'h1CE;
        z_req = 0; z_valid = 0; z_temp = '0;
        repeat (2) step();
        check("rst_main", {busy, sensor_en, meas_ack, temp_valid, alarm_hi, alarm_lo, timeout_err, temp_avg}, '0);
        check("rst_z", {z_busy, z_en, z_ack, z_tv, z_hi, z_lo, z_err, z_avg}, '0);
        reset_n = 1;
        step();

        // Basic average; sample in the last settle cycle is ignored
        request();
        check("t1_start", {busy, sensor_en}, 2'b11);
        repeat (S - 1) step();
        feed(9'd99);
        feed(9'd30); feed(9'd10); feed(9'd11); feed(9'd12); feed(9'd13);
        check("t1_done", {temp_valid, meas_ack, busy, sensor_en}, 4'b1100);
        check("t1_avg", temp_avg, 9'd11);

        // Negative floor and low alarm
        step();
        hi_thresh = 9'd0; lo_thresh = 9'h1FA;
        request();
        repeat (S) step();
        feed(9'd0); feed(9'h1FB); feed(9'h1FA); feed(9'h1FA); feed(9'h1FA);
        check("t2_avg", temp_avg, 9'h1FA);
        check("t2_alarm", {temp_valid, alarm_hi, alarm_lo}, 3'b101);

        // Watchdog after two accumulated samples
        step();
        request();
        repeat (S) step();
        feed(9'd5); feed(9'd7); feed(9'd8);
        n = 1;
        while (!meas_ack && n < 40) begin
            step();
            n++;
        end
        check("wd_latency", n, 16);
        check("wd_flags", {timeout_err, temp_valid, busy}, 3'b100);
        check("wd_avg", temp_avg, 9'h1FA);
        clear_err = 1;
        step();
        clear_err = 0;
        check("wd_clear", timeout_err, 1'b0);

        // Request coinciding with a periodic tick merges into one measurement
        step();
        periodic_en = 1;
        repeat (P - 1) step();
        request();
        repeat (S) step();
        feed(9'd0); feed(9'd1); feed(9'd2); feed(9'd3); feed(9'd4);
        check("t4_done", {meas_ack, temp_valid}, 2'b11);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_merge", busy, 1'b0);
        end
        periodic_en = 0;

        // Request during busy restarts one cycle after completion
        request();
        step();
        request();
        repeat (2) step();
        feed(9'd0); feed(9'd1); feed(9'd1); feed(9'd1); feed(9'd1);
        check("t4b_done", {meas_ack, busy}, 2'b10);
        step();
        check("t4b_restart", busy, 1'b1);
        repeat (S) step();
        feed(9'd0); feed(9'd40); feed(9'd41); feed(9'd42); feed(9'd43);
        check("t4b_avg", temp_avg, 9'd41);

        // Reset mid-accumulation, then fresh samples only
        step();
        request();
        repeat (S) step();
        feed(9'd0); feed(9'd100); feed(9'd100);
        reset_n = 0;
        step();
        reset_n = 1;
        check("t5_rst", {busy, temp_valid, meas_ack, alarm_hi, alarm_lo, timeout_err, temp_avg}, '0);
        request();
        repeat (S) step();
        feed(9'd0); feed(9'd20); feed(9'd21); feed(9'd22); feed(9'd23);
        check("t5_avg", temp_avg, 9'd21);

        // Single-sample averaging at the signed extremes
        step();
        hi_thresh = 9'd255; lo_thresh = 9'h100;
        z_req = 1; step(); z_req = 0;
        check("z_start", {z_busy, z_en}, 2'b11);
        repeat (S) step();
        z_valid = 1; z_temp = 9'd255; step();
        z_temp = 9'h100; step();
        z_valid = 0;
        check("z_avg_min", z_avg, 9'h100);
        check("z_done1", {z_tv, z_ack, z_hi, z_lo, z_busy}, 5'b11010);
        step();
        z_req = 1; step(); z_req = 0;
        repeat (S) step();
        z_valid = 1; z_temp = 9'd0; step();
        z_temp = 9'd255; step();
        z_valid = 0;
        check("z_avg_max", z_avg, 9'd255);
        check("z_done2", {z_tv, z_ack, z_hi, z_lo, z_busy}, 5'b11100);

        // Randomized traffic with quiet stretches to provoke timeouts
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) quiet = !quiet;
            if ($urandom_range(0, 199) == 0) periodic_en = !periodic_en;
            if ($urandom_range(0, 49) == 0) begin
                hi_thresh = 9'($urandom);
                lo_thresh = 9'($urandom);
            end
            reset_n      = $urandom_range(0, 599) != 0;
            meas_req     = $urandom_range(0, 29) == 0;
            clear_err    = $urandom_range(0, 39) == 0;
            sample_valid = !quiet && $urandom_range(0, 2) == 0;
            sample_temp  = 9'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
